stopwatch_ctrl: RTL
===================

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500_000, clk cycles per 10 ms tick (50 MHz clk).
REQ-002 SHALL have port clk  input  1  system clock, 50 MHz.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ss_pulse  input  1  debounced start/stop key press, one-cycle active-high pulse.
REQ-005 SHALL have port lap_pulse  input  1  debounced lap/clear key press, one-cycle active-high pulse.
REQ-006 SHALL have port disp_bcd  output  24  displayed time {min_t,min_u,sec_t,sec_u,cs_t,cs_u}, 4-bit BCD each.
REQ-007 SHALL have port running  output  1  high in RUN or LAP.
REQ-008 SHALL have port lap_active  output  1  high in LAP (display frozen).
REQ-009 SHALL have port overflow  output  1  sticky flag, time wrapped past 59:59.99.

Function
REQ-010 SHALL implement FSM states IDLE, RUN, LAP, PAUSE; state registered, change visible the cycle after the accepted pulse.
REQ-011 IDLE: ss_pulse -> RUN; lap_pulse ignored.
REQ-012 RUN: ss_pulse -> PAUSE; lap_pulse -> LAP, latching current live time into the display register on the same edge.
REQ-013 LAP: ss_pulse -> PAUSE (display returns to live time); lap_pulse -> RUN (display live again).
REQ-014 PAUSE: ss_pulse -> RUN; lap_pulse -> IDLE, clearing time to 00:00.00, divider to 0 and overflow to 0.
REQ-015 ss_pulse and lap_pulse in the same cycle: ss_pulse wins, lap_pulse dropped.
REQ-016 Tick divider SHALL count 0..TICK_DIV-1 only in RUN/LAP, emit one-cycle tick at TICK_DIV-1 and wrap to 0; held (not cleared) in PAUSE; cleared on IDLE->RUN.
REQ-017 Each tick SHALL advance time by 0.01 s as BCD cascade: cs 00..99, sec 00..59, min 00..59; carries ripple in the same cycle.
REQ-018 Tick at 59:59.99 SHALL wrap time to 00:00.00 and set overflow; overflow stays set until IDLE entry or reset.
REQ-019 Time counter SHALL keep advancing in LAP while display stays frozen.
REQ-020 disp_bcd SHALL be registered: equals live time one cycle after it updates in IDLE/RUN/PAUSE; holds latched value in LAP.
REQ-021 Every BCD digit SHALL only ever hold legal values (tens of sec/min 0..5, others 0..9).

Reset
REQ-022 rst low SHALL asynchronously force state IDLE, divider 0, time 00:00.00, disp_bcd 24'h000000, running 0, lap_active 0, overflow 0.
REQ-023 Reset asserted mid-RUN/LAP SHALL abort immediately; after release a single ss_pulse restarts from 00:00.00.

Structure
REQ-024 Shared package stopwatch_pkg SHALL hold the state enum, default TICK_DIV and the BCD digit-limit constants (9, 5).
REQ-025 BCD cascade SHALL be a sub-module bcd_time_cnt (inputs clk, rst, clr, tick; outputs six digits, wrap pulse); FSM, divider and display latch stay in stopwatch_ctrl.

Verification (TICK_DIV=4)
REQ-026 Reset then ss_pulse, run 400 cycles -> running=1, disp_bcd=24'h000100 (1.00 s).
REQ-027 RUN at 00:00.05, lap_pulse -> lap_active=1, disp_bcd held 24'h000005 for 40 cycles; lap_pulse -> display jumps to live 24'h000015.
REQ-028 ss_pulse at 00:00.07 plus 2 divider cycles, wait 100 cycles, ss_pulse -> exactly 2 cycles later first tick, display 24'h000008.
REQ-029 Force time 59:59.99 via run-up, one tick -> disp_bcd=24'h000000, overflow=1; PAUSE then lap_pulse -> IDLE, overflow=0.
REQ-030 ss_pulse and lap_pulse same cycle in RUN -> PAUSE, lap_active=0; rst low mid-RUN -> all outputs zero within same cycle.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller and its BCD time counter.
package stopwatch_pkg;

    // Operating modes of the stopwatch controller.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_LAP   = 2'd2,
        ST_PAUSE = 2'd3
    } sw_state_e;

    // Clock cycles per 10 ms tick with a 50 MHz clock.
    localparam int unsigned TICK_DIV_DEFAULT = 500_000;

    // Largest legal value of a units digit and of a seconds/minutes tens digit.
    localparam logic [3:0] BCD_MAX_UNITS = 4'd9;
    localparam logic [3:0] BCD_MAX_TENS6 = 4'd5;

    // Advance one BCD digit, wrapping to zero after its limit.
    function automatic logic [3:0] bcd_inc(input logic [3:0] digit, input logic [3:0] limit);
        return (digit == limit) ? 4'd0 : digit + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_time_cnt.sv
// mm:ss.cc time counter kept directly in BCD; a tick ripples carries through
// all six digits in the same cycle and flags the 59:59.99 -> 00:00.00 wrap.
module bcd_time_cnt
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       tick,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic [3:0] cs_t,
    output logic [3:0] cs_u,
    output logic       wrap
);

    logic [3:0] min_t_q, min_u_q, sec_t_q, sec_u_q, cs_t_q, cs_u_q;
    logic [3:0] min_t_d, min_u_d, sec_t_d, sec_u_d, cs_t_d, cs_u_d;

    // Carry into each digit: the tick itself, then every lower digit at its limit.
    logic c_cs_t, c_sec_u, c_sec_t, c_min_u, c_min_t;

    assign c_cs_t  = tick    && (cs_u_q  == BCD_MAX_UNITS);
    assign c_sec_u = c_cs_t  && (cs_t_q  == BCD_MAX_UNITS);
    assign c_sec_t = c_sec_u && (sec_u_q == BCD_MAX_UNITS);
    assign c_min_u = c_sec_t && (sec_t_q == BCD_MAX_TENS6);
    assign c_min_t = c_min_u && (min_u_q == BCD_MAX_UNITS);
    assign wrap    = c_min_t && (min_t_q == BCD_MAX_TENS6);

    // Next digit values: clear wins, otherwise each digit steps on its carry-in.
    always_comb begin
        // NOTE: every output of this block is given a hold value first so no path leaves it unassigned, which would infer a latch.
        cs_u_d  = cs_u_q;
        cs_t_d  = cs_t_q;
        sec_u_d = sec_u_q;
        sec_t_d = sec_t_q;
        min_u_d = min_u_q;
        min_t_d = min_t_q;
        if (clr) begin
            cs_u_d  = '0;
            cs_t_d  = '0;
            sec_u_d = '0;
            sec_t_d = '0;
            min_u_d = '0;
            min_t_d = '0;
        end else begin
            if (tick)    cs_u_d  = bcd_inc(cs_u_q,  BCD_MAX_UNITS);
            if (c_cs_t)  cs_t_d  = bcd_inc(cs_t_q,  BCD_MAX_UNITS);
            if (c_sec_u) sec_u_d = bcd_inc(sec_u_q, BCD_MAX_UNITS);
            if (c_sec_t) sec_t_d = bcd_inc(sec_t_q, BCD_MAX_TENS6);
            if (c_min_u) min_u_d = bcd_inc(min_u_q, BCD_MAX_UNITS);
            if (c_min_t) min_t_d = bcd_inc(min_t_q, BCD_MAX_TENS6);
        end
    end

    // Digit registers, asynchronously cleared by reset.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            cs_u_q  <= '0;
            cs_t_q  <= '0;
            sec_u_q <= '0;
            sec_t_q <= '0;
            min_u_q <= '0;
            min_t_q <= '0;
        end else begin
            cs_u_q  <= cs_u_d;
            cs_t_q  <= cs_t_d;
            sec_u_q <= sec_u_d;
            sec_t_q <= sec_t_d;
            min_u_q <= min_u_d;
            min_t_q <= min_t_d;
        end
    end

    assign min_t = min_t_q;
    assign min_u = min_u_q;
    assign sec_t = sec_t_q;
    assign sec_u = sec_u_q;
    assign cs_t  = cs_t_q;
    assign cs_u  = cs_u_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: start/stop and lap/clear FSM, 10 ms tick divider,
// lap display latch and sticky overflow flag around the BCD time counter.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ss_pulse,
    input  logic        lap_pulse,
    output logic [23:0] disp_bcd,
    output logic        running,
    output logic        lap_active,
    output logic        overflow
);

    localparam int unsigned DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    sw_state_e         state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [23:0]       disp_q, disp_d;
    logic              overflow_q, overflow_d;

    logic              counting, tick, clr, wrap;
    logic [3:0]        min_t, min_u, sec_t, sec_u, cs_t, cs_u;
    logic [23:0]       live_bcd;

    assign counting = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick     = counting && (div_q == DIV_LAST);
    assign clr      = (state_q == ST_PAUSE) && (state_d == ST_IDLE);
    assign live_bcd = {min_t, min_u, sec_t, sec_u, cs_t, cs_u};

    // Mode transitions; a start/stop press takes priority over a simultaneous lap press.
    always_comb begin
        state_d = state_q;
        if (ss_pulse) begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_LAP:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
            endcase
        end else if (lap_pulse) begin
            unique case (state_q)
                ST_IDLE:  state_d = ST_IDLE;
                ST_RUN:   state_d = ST_LAP;
                ST_LAP:   state_d = ST_RUN;
                ST_PAUSE: state_d = ST_IDLE;
            endcase
        end
    end

    // Divider, display latch and overflow next-state.
    always_comb begin
        div_d      = div_q;
        disp_d     = live_bcd;
        overflow_d = overflow_q;
        // Divider runs while counting, holds in PAUSE, and is zero whenever IDLE is left or entered.
        if (counting) begin
            div_d = tick ? '0 : div_q + 1'b1;
        end else if ((state_q == ST_IDLE) || clr) begin
            div_d = '0;
        end
        // Display freezes only while LAP persists; RUN->LAP captures the live time on the same edge.
        if ((state_q == ST_LAP) && (state_d == ST_LAP)) begin
            disp_d = disp_q;
        end
        if (clr) begin
            overflow_d = 1'b0;
        end else if (wrap) begin
            overflow_d = 1'b1;
        end
    end

    // Controller registers.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: only control/state flops here, all with asynchronous reset to a known display and mode.
        if (!rst) begin
            state_q    <= ST_IDLE;
            div_q      <= '0;
            disp_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            disp_q     <= disp_d;
            overflow_q <= overflow_d;
        end
    end

    bcd_time_cnt u_time (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .tick  (tick),
        .min_t (min_t),
        .min_u (min_u),
        .sec_t (sec_t),
        .sec_u (sec_u),
        .cs_t  (cs_t),
        .cs_u  (cs_u),
        .wrap  (wrap)
    );

    assign disp_bcd   = disp_q;
    assign running    = counting;
    assign lap_active = (state_q == ST_LAP);
    assign overflow   = overflow_q;

endmodule
